// File: rtl/pixel_generator.sv
`default_nettype none
// ============================================================================
// Module      : pixel_generator
// Description : Procedural 640x480 RGB888 video source. Four 24-bit pixels
//               are packed into three 32-bit AXI4-Stream words per group
//               (tuser = start of frame, tlast = end of line). An AXI4-Lite
//               register bank supplies per-frame R/G/B colour offsets.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_generator #(
  parameter int X_PIXELS  = 640,
  parameter int Y_LINES   = 480,
  parameter int REG_COUNT = 8
) (
  input  logic        out_stream_aclk,
  input  logic        axi_reset,
  // Video stream
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  // AXI4-Lite write
  input  logic [7:0]  s_axi_lite_awaddr,
  input  logic        s_axi_lite_awvalid,
  output logic        s_axi_lite_awready,
  input  logic [31:0] s_axi_lite_wdata,
  input  logic        s_axi_lite_wvalid,
  output logic        s_axi_lite_wready,
  output logic [1:0]  s_axi_lite_bresp,
  output logic        s_axi_lite_bvalid,
  input  logic        s_axi_lite_bready,
  // AXI4-Lite read
  input  logic [7:0]  s_axi_lite_araddr,
  input  logic        s_axi_lite_arvalid,
  output logic        s_axi_lite_arready,
  output logic [31:0] s_axi_lite_rdata,
  output logic [1:0]  s_axi_lite_rresp,
  output logic        s_axi_lite_rvalid,
  input  logic        s_axi_lite_rready
);

  localparam int c_x_words = X_PIXELS * 3 / 4;
  localparam int c_xw      = (X_PIXELS > 1)  ? $clog2(X_PIXELS)  : 1;
  localparam int c_yw      = (Y_LINES > 1)   ? $clog2(Y_LINES)   : 1;
  localparam int c_aw      = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  // x of the last 4-pixel group in a line (three words per group)
  localparam logic [c_xw-1:0] c_last_x = c_xw'((c_x_words / 3 - 1) * 4);
  localparam logic [c_yw-1:0] c_last_y = c_yw'(Y_LINES - 1);

  // Word phase within a 4-pixel group
  localparam logic [1:0] c_ph0 = 2'd0;
  localparam logic [1:0] c_ph1 = 2'd1;
  localparam logic [1:0] c_ph2 = 2'd2;

  // ---------------------------------------------------------------- storage
  logic [31:0]     r_regs [REG_COUNT];
  logic [7:0]      r_sh_r, r_sh_g, r_sh_b;

  // Counters describe the next word to be generated, not the one on the bus
  logic [c_xw-1:0] r_x;
  logic [c_yw-1:0] r_y;
  logic [15:0]     r_frame;
  logic [1:0]      r_phase;

  logic [31:0]     r_tdata;
  logic            r_tvalid, r_tuser, r_tlast;

  logic            r_awready, r_bvalid;
  logic            r_arready, r_rvalid;
  logic [31:0]     r_rdata;

  // ---------------------------------------------------------- next-word math
  logic            w_first, w_eol, w_load;
  logic [7:0]      w_r_off, w_g_off, w_b_off;
  logic [7:0]      w_x8, w_r0, w_r1, w_r2, w_r3, w_g, w_b;
  logic [23:0]     w_p0, w_p1, w_p2, w_p3;
  logic [31:0]     w_word;
  logic [c_aw-1:0] w_widx, w_ridx;
  logic            w_unused_addr;

  assign w_first = (r_x == '0) && (r_y == '0) && (r_phase == c_ph0);
  assign w_eol   = (r_x == c_last_x) && (r_phase == c_ph2);

  // Output register is refilled whenever it is empty or being consumed
  assign w_load  = !r_tvalid || out_stream_tready;

  // Word 0 of a frame uses the live registers; the rest of the frame uses
  // the copies captured when that word was generated.
  assign w_r_off = w_first ? r_regs[0][7:0] : r_sh_r;
  assign w_g_off = w_first ? r_regs[1][7:0] : r_sh_g;
  assign w_b_off = w_first ? r_regs[2][7:0] : r_sh_b;

  assign w_x8 = 8'(r_x);
  assign w_r0 = w_x8 + w_r_off;
  assign w_r1 = w_x8 + 8'd1 + w_r_off;
  assign w_r2 = w_x8 + 8'd2 + w_r_off;
  assign w_r3 = w_x8 + 8'd3 + w_r_off;
  assign w_g  = 8'(r_y) + w_g_off;
  assign w_b  = r_frame[7:0] + w_b_off;

  assign w_p0 = {w_r0, w_g, w_b};
  assign w_p1 = {w_r1, w_g, w_b};
  assign w_p2 = {w_r2, w_g, w_b};
  assign w_p3 = {w_r3, w_g, w_b};

  // Select the 32-bit slice of the packed 96-bit pixel group for this phase
  always_comb begin
    w_word = {w_p1[7:0], w_p0};
    case (r_phase)
      c_ph1:   w_word = {w_p2[15:0], w_p1[23:8]};
      c_ph2:   w_word = {w_p3, w_p2[23:16]};
      default: w_word = {w_p1[7:0], w_p0};
    endcase
  end

  // Stream output register and x/y/frame/phase counter advance
  always_ff @(posedge out_stream_aclk) begin
    if (axi_reset) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= 1'b0;
      r_tlast  <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_frame  <= '0;
      r_phase  <= c_ph0;
      r_sh_r   <= '0;
      r_sh_g   <= '0;
      r_sh_b   <= '0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_word;
      r_tuser  <= w_first;
      r_tlast  <= w_eol;
      if (w_first) begin
        r_sh_r <= r_regs[0][7:0];
        r_sh_g <= r_regs[1][7:0];
        r_sh_b <= r_regs[2][7:0];
      end
      if (r_phase == c_ph2) begin
        r_phase <= c_ph0;
        if (r_x == c_last_x) begin
          r_x <= '0;
          if (r_y == c_last_y) begin
            r_y     <= '0;
            r_frame <= r_frame + 16'd1;
          end else begin
            r_y <= r_y + c_yw'(1);
          end
        end else begin
          r_x <= r_x + c_xw'(4);
        end
      end else begin
        r_phase <= r_phase + 2'd1;
      end
    end
  end

  // ------------------------------------------------------------- AXI4-Lite
  assign w_widx = s_axi_lite_awaddr[c_aw+1:2];
  assign w_ridx = s_axi_lite_araddr[c_aw+1:2];
  // Upper address bits alias; they are intentionally ignored
  assign w_unused_addr = ^{s_axi_lite_awaddr[7:c_aw+2], s_axi_lite_awaddr[1:0],
                           s_axi_lite_araddr[7:c_aw+2], s_axi_lite_araddr[1:0]};

  // Write channel: one-cycle aw/w ready pulse, register update, held bvalid
  always_ff @(posedge out_stream_aclk) begin
    if (axi_reset) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      if (r_awready) begin
        r_awready <= 1'b0;
      end else if (s_axi_lite_awvalid && s_axi_lite_wvalid && !r_bvalid) begin
        r_awready <= 1'b1;
      end
      if (r_awready && s_axi_lite_awvalid && s_axi_lite_wvalid) begin
        r_regs[w_widx] <= s_axi_lite_wdata;
        r_bvalid       <= 1'b1;
      end else if (r_bvalid && s_axi_lite_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: one-cycle arready pulse, latched data, held rvalid.
  // A same-cycle write lands after this sample, so the old value is returned.
  always_ff @(posedge out_stream_aclk) begin
    if (axi_reset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (r_arready) begin
        r_arready <= 1'b0;
      end else if (s_axi_lite_arvalid && !r_rvalid) begin
        r_arready <= 1'b1;
      end
      if (r_arready && s_axi_lite_arvalid) begin
        r_rdata  <= r_regs[w_ridx];
        r_rvalid <= 1'b1;
      end else if (r_rvalid && s_axi_lite_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign out_stream_tdata   = r_tdata;
  assign out_stream_tkeep   = 4'hF;
  assign out_stream_tlast   = r_tlast;
  assign out_stream_tuser   = r_tuser;
  assign out_stream_tvalid  = r_tvalid;

  assign s_axi_lite_awready = r_awready;
  assign s_axi_lite_wready  = r_awready;
  assign s_axi_lite_bresp   = 2'b00;
  assign s_axi_lite_bvalid  = r_bvalid;
  assign s_axi_lite_arready = r_arready;
  assign s_axi_lite_rdata   = r_rdata;
  assign s_axi_lite_rresp   = 2'b00;
  assign s_axi_lite_rvalid  = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_pixel_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_generator
// Description : Scoreboard bench for pixel_generator on a reduced 16x4 frame.
//               A line-level byte model feeds an expected-word queue; a
//               monitor pops and compares on every stream transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_generator;

  localparam int TX = 16;
  localparam int TY = 4;
  localparam int TW = TX * 3 / 4;
  localparam int FW = TW * TY;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid;
  logic        tready = 1'b0;
  logic [7:0]  awaddr = '0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready = 1'b0;
  logic [7:0]  araddr = '0;
  logic        arvalid = 1'b0, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready = 1'b0;

  always #5 clk = ~clk;

  pixel_generator #(.X_PIXELS(TX), .Y_LINES(TY), .REG_COUNT(8)) dut (
    .out_stream_aclk(clk), .axi_reset(rst),
    .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tlast(tlast),
    .out_stream_tuser(tuser), .out_stream_tvalid(tvalid), .out_stream_tready(tready),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
    .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
    .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
    .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
    .s_axi_lite_rready(rready)
  );

  typedef struct {
    logic [31:0] d;
    logic        u;
    logic        l;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_regs [8];
  int          m_y = 0;
  int          m_frame = 0;
  int          mon_total = 0;
  int          mode = 0;
  logic [31:0] mon_log [16];

  // Reference model: build each line as a little-endian byte stream of
  // B,G,R triplets and slice it into 32-bit words.
  initial begin : producer
    logic [7:0] lb [TX*3];
    logic [7:0] ro, go, bo;
    exp_t       e;
    ro = '0; go = '0; bo = '0;
    forever begin
      wait (!rst && q.size() == 0);
      if (m_y == 0) begin
        ro = m_regs[0][7:0];
        go = m_regs[1][7:0];
        bo = m_regs[2][7:0];
      end
      for (int i = 0; i < TX; i++) begin
        lb[3*i]   = 8'(m_frame) + bo;
        lb[3*i+1] = 8'(m_y) + go;
        lb[3*i+2] = 8'(i) + ro;
      end
      for (int k = 0; k < TW; k++) begin
        e.d = {lb[4*k+3], lb[4*k+2], lb[4*k+1], lb[4*k]};
        e.u = (m_y == 0) && (k == 0);
        e.l = (k == TW - 1);
        q.push_back(e);
      end
      m_y++;
      if (m_y == TY) begin
        m_y     = 0;
        m_frame = (m_frame + 1) & 16'hFFFF;
      end
    end
  end

  // Sink ready pattern: 0 always, 1 random, 2 pulse after valid, 3 stalled
  initial begin : driver
    forever begin
      @(posedge clk); #1;
      case (mode)
        0:       tready = 1'b1;
        1:       tready = 1'($urandom_range(0, 1));
        2:       tready = tvalid && !tready;
        default: tready = 1'b0;
      endcase
    end
  end

  // Monitor: continuity, stall stability and scoreboard comparison
  initial begin : monitor
    logic        hold;
    logic [31:0] hd;
    logic        hu, hl;
    int          since;
    exp_t        e;
    hold = 1'b0; hd = '0; hu = 1'b0; hl = 1'b0; since = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold  = 1'b0;
        since = 0;
      end else begin
        since++;
        if (since >= 3) begin
          checks++;
          if (!tvalid) begin
            errors++;
            $display("FAIL tvalid_continuous: tvalid=%0b required 1 at %0t", tvalid, $time);
          end
        end
        if (hold) begin
          checks++;
          if ({tdata, tuser, tlast} !== {hd, hu, hl}) begin
            errors++;
            $display("FAIL stall_hold: got %h/%0b/%0b required %h/%0b/%0b", tdata, tuser, tlast, hd, hu, hl);
          end
        end
        if (tvalid && tready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h with empty expectation queue", tdata);
          end else begin
            e = q.pop_front();
            if ({tdata, tuser, tlast} !== {e.d, e.u, e.l}) begin
              errors++;
              $display("FAIL word%0d: got data=%h user=%0b last=%0b required data=%h user=%0b last=%0b",
                       mon_total, tdata, tuser, tlast, e.d, e.u, e.l);
            end
          end
          if (mon_total < 16) mon_log[mon_total] = tdata;
          mon_total++;
        end
        hold = tvalid && !tready;
        hd = tdata; hu = tuser; hl = tlast;
      end
    end
  end

  task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    m_y = 0;
    m_frame = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    mon_total = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check32("reset_outputs",
            {22'd0, tvalid, tuser, tlast, awready, wready, bvalid, arready, rvalid, tkeep},
            {22'd0, 8'd0, 4'hF});
    check32("reset_tdata", tdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int t;
    t = 0;
    while (mon_total < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (mon_total < n) begin
      errors++;
      $display("FAIL wait_words: got %0d words required %0d", mon_total, n);
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d);
    int t;
    @(posedge clk); #1;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!(awready && wready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!(awready && wready)) begin
      errors++;
      $display("FAIL aw_handshake: awready=%0b wready=%0b required 1", awready, wready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bvalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check32("bresp", {29'd0, bvalid, bresp}, {29'd0, 1'b1, 2'b00});
    @(posedge clk); #1;
    bready = 1'b0;
    m_regs[a[4:2]] = d;
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] req, input string nm);
    int t;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rvalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check32({nm, "_rresp"}, {29'd0, rvalid, rresp}, {29'd0, 1'b1, 2'b00});
    check32(nm, rdata, req);
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          tgt, t0;
    logic [31:0] v;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;

    // Always-ready frames with zero offsets
    mode = 0;
    apply_reset(3);
    wait_words(2 * FW + 2);
    check32("f0_word0", mon_log[0], 32'h0000_0000);
    check32("f0_word1", mon_log[1], 32'h0000_0100);
    check32("f0_word2", mon_log[2], 32'h0300_0002);
    check32("f0_line1_word0", mon_log[TW], 32'h0000_0100);

    // Mid-frame R offset write; takes effect at the next frame only
    wait_words(2 * FW + 10);
    axi_write(8'h00, 32'h0000_0010);
    axi_read(8'h00, 32'h0000_0010, "reg0_readback");
    wait_words(3 * FW + 4);

    // Scratch register, address aliasing, simultaneous read/write
    v = $urandom;
    axi_write(8'h2C, v);
    axi_read(8'h0C, v, "reg3_alias");
    axi_write(8'h14, 32'hA5A5_0001);
    v = $urandom;
    fork
      axi_write(8'h14, v);
      axi_read(8'h14, 32'hA5A5_0001, "reg5_old_value");
    join
    axi_read(8'hF4, v, "reg5_new_value");

    // Random back-pressure with new G/B offsets
    mode = 1;
    tgt = (mon_total / FW + 1) * FW + 5;
    wait_words(tgt);
    axi_write(8'h04, $urandom);
    axi_write(8'h08, $urandom);
    wait_words(mon_total + 3 * FW);

    // Ready-after-valid: exactly one word every two cycles
    mode = 2;
    repeat (4) @(negedge clk);
    t0 = mon_total;
    repeat (40) @(negedge clk);
    check32("pulse_throughput", 32'(mon_total - t0), 32'd20);
    wait_words(mon_total + FW + TW);

    // One-cycle reset in the middle of line 2
    mode = 0;
    tgt = (mon_total / FW + 1) * FW + 2 * TW + 5;
    wait_words(tgt);
    apply_reset(1);
    wait_words(FW + 3);
    check32("restart_word0", mon_log[0], 32'h0000_0000);
    check32("restart_word2", mon_log[2], 32'h0300_0002);
    axi_read(8'h00, 32'h0, "reg0_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
